// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory/I-O controller: RAM geometry and read FSM states.
package cpu_pkg;

    localparam int RAM_DEPTH = 256;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = $clog2(RAM_DEPTH);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_DRIVE
    } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers; a push on a full FIFO only lands when a pop
// happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// CPU-side memory and I/O controller: 256x8 RAM with a latency-configurable read path,
// an output-port FIFO and a stalling input port, all sharing one tri-state data bus.
module mem_io_ctrl
    import cpu_pkg::*;
#(
    parameter int READ_LAT  = 1,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_bus,
    input  logic              c_ri,
    input  logic              c_ro,
    input  logic              mem_clk,
    input  logic              mem_io,
    inout  wire  [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              out_ovf
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

    logic [DATA_W-1:0]         ram [RAM_DEPTH];
    rd_state_t                 state_q, state_d;
    logic [1:0]                lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0]         rd_addr_q;
    logic                      acc_rd, acc_wr;
    logic                      cpu_ram_wr, rd_start;
    logic                      out_push, out_pop, push_ok;
    logic                      fifo_full, fifo_empty;
    logic [$clog2(OUT_DEPTH):0] fifo_count;
    logic                      ram_drive, in_drive, in_drive_q;

    // A read strobe always takes precedence over a simultaneous write strobe.
    assign acc_rd     = c_ro && mem_clk;
    assign acc_wr     = c_ri && mem_clk && !acc_rd;
    assign cpu_ram_wr = acc_wr && !mem_io;
    assign out_push   = acc_wr && mem_io;
    assign rd_start   = (state_q == RD_IDLE) && acc_rd && !mem_io;

    always_ff @(posedge clk) begin
        if (prog_we)
            ram[prog_addr] <= prog_data;
        else if (cpu_ram_wr)
            ram[addr_bus] <= bus;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RD_IDLE;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_start) rd_addr_q <= addr_bus;
    end

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            RD_IDLE: begin
                if (rd_start) begin
                    state_d   = RD_WAIT;
                    lat_cnt_d = '0;
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q == LAT_LAST)
                    state_d = RD_DRIVE;
                else
                    lat_cnt_d = lat_cnt_q + 1'b1;
            end
            RD_DRIVE: begin
                if (!c_ro) state_d = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Reset gates both drivers combinationally so the bus releases in the reset cycle itself.
    assign ram_drive = (state_q == RD_DRIVE) && !reset;
    assign in_drive  = c_ro && mem_io && in_valid && (state_q != RD_DRIVE) && !reset;
    assign bus       = ram_drive ? ram[rd_addr_q] : (in_drive ? in_data : 8'bz);

    always_ff @(posedge clk) begin
        if (reset) in_drive_q <= 1'b0;
        else       in_drive_q <= in_drive;
    end

    assign in_ready = in_drive && !in_drive_q;

    assign out_valid = (fifo_count != '0);
    assign out_pop   = out_ready && !fifo_empty;
    assign push_ok   = !fifo_full || out_pop;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (out_push && push_ok),
        .push_data (bus),
        .pop       (out_pop),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset)
            out_ovf <= 1'b0;
        else if (out_push && !push_ok)
            out_ovf <= 1'b1;
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Randomized bench for mem_io_ctrl against a cycle-level behavioural model of RAM, FIFO and ports.
module tb_mem_io_ctrl;

    localparam int READ_LAT  = 1;
    localparam int OUT_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr_bus;
    logic       c_ri, c_ro, mem_clk, mem_io;
    logic       out_ready, in_valid, prog_we;
    logic [7:0] in_data, prog_addr, prog_data;
    logic       tb_drv;
    logic [7:0] tb_data;
    wire  [7:0] bus;
    wire  [7:0] out_data;
    wire        out_valid, in_ready, out_ovf;

    assign bus = tb_drv ? tb_data : 8'hzz;

    always #5 clk = ~clk;

    mem_io_ctrl #(.READ_LAT(READ_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .reset(reset), .addr_bus(addr_bus), .c_ri(c_ri), .c_ro(c_ro),
        .mem_clk(mem_clk), .mem_io(mem_io), .bus(bus),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .out_ovf(out_ovf)
    );

    // Model state: RAM image, FIFO contents, sticky overflow, pending read timed by edge index.
    logic [7:0] ram_m [256];
    logic [7:0] fq [$];
    bit         ovf_m, rd_busy, in_prev, check_en;
    int         rd_a, edge_n;
    logic [7:0] rd_addr;
    int         n_checks, n_fail;

    logic [7:0] bus_seen, out_data_seen;
    bit         bus_z_seen, out_valid_seen, in_ready_seen, ovf_seen;

    function automatic bit readDriving();
        return rd_busy && (edge_n - 1 >= rd_a + READ_LAT);
    endfunction

    function automatic bit expRamDrive();
        return !reset && readDriving();
    endfunction

    function automatic bit expInDrive();
        return !reset && c_ro && mem_io && in_valid && !readDriving();
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input bit act, input bit exp);
        checkOutput(name, {7'b0, act}, {7'b0, exp});
    endtask

    // Advance one clock edge and apply the specification's rules to the model at that edge.
    task automatic applyStimulus();
        bit ar, aw, pop, in_now;
        @(posedge clk);
        ar     = c_ro && mem_clk;
        aw     = c_ri && mem_clk && !ar;
        in_now = expInDrive();
        if (prog_we)
            ram_m[prog_addr] = prog_data;
        else if (aw && !mem_io)
            ram_m[addr_bus] = tb_data;
        if (reset) begin
            rd_busy = 0;
            fq.delete();
            ovf_m   = 0;
            in_prev = 0;
        end else begin
            pop = (fq.size() != 0) && out_ready;
            if (aw && mem_io) begin
                if (fq.size() < OUT_DEPTH || pop) begin
                    if (pop) void'(fq.pop_front());
                    fq.push_back(tb_data);
                end else begin
                    ovf_m = 1;
                end
            end else if (pop) begin
                void'(fq.pop_front());
            end
            if (rd_busy) begin
                if (edge_n > rd_a + READ_LAT && !c_ro) rd_busy = 0;
            end else if (ar && !mem_io) begin
                rd_busy = 1;
                rd_a    = edge_n;
                rd_addr = addr_bus;
            end
            in_prev = in_now;
        end
        edge_n++;
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            bus_z_seen     = (bus === 8'hzz);
            bus_seen       = bus;
            out_valid_seen = out_valid;
            out_data_seen  = out_data;
            in_ready_seen  = in_ready;
            ovf_seen       = out_ovf;
            if (check_en) begin
                checkBit("out_valid", out_valid, fq.size() != 0);
                if (fq.size() != 0) checkOutput("out_data", out_data, fq[0]);
                checkBit("out_ovf", out_ovf, ovf_m);
                checkBit("in_ready", in_ready, expInDrive() && !in_prev);
                if (tb_drv)             checkOutput("bus_tb", bus, tb_data);
                else if (expRamDrive()) checkOutput("bus_ram", bus, ram_m[rd_addr]);
                else if (expInDrive())  checkOutput("bus_in", bus, in_data);
                else                    checkBit("bus_hiz", bus_z_seen, 1'b1);
            end
        end
    end

    task automatic progWrite(input logic [7:0] a, input logic [7:0] d);
        prog_we = 1; prog_addr = a; prog_data = d;
        applyStimulus();
        prog_we = 0;
    endtask

    task automatic cpuWrite(input bit io, input logic [7:0] a, input logic [7:0] d, input bit pre);
        c_ri = 1; mem_io = io; addr_bus = a; tb_drv = 1; tb_data = d;
        if (pre) begin
            mem_clk = 0;
            applyStimulus();
        end
        mem_clk = 1;
        applyStimulus();
        c_ri = 0; tb_drv = 0; mem_clk = 0;
    endtask

    task automatic cpuRead(input logic [7:0] a, input int hold, output logic [7:0] d, output int lat);
        c_ro = 1; mem_clk = 1; mem_io = 0; addr_bus = a;
        applyStimulus();
        mem_clk  = 1'($urandom_range(0, 1));
        addr_bus = 8'($urandom);
        lat = 0;
        d   = 8'h00;
        for (int k = 1; k <= 16; k++) begin
            applyStimulus();
            if (!bus_z_seen) begin
                lat = k;
                d   = bus_seen;
                break;
            end
        end
        if (lat == 0) checkBit("read_timeout", 1'b0, 1'b1);
        repeat (hold) applyStimulus();
        c_ro = 0; mem_clk = 0;
        applyStimulus();
    endtask

    task automatic drain(input int cycles, output logic [7:0] got [$]);
        got.delete();
        out_ready = 1;
        repeat (cycles) begin
            applyStimulus();
            if (out_valid_seen) got.push_back(out_data_seen);
        end
        out_ready = 0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] got [$];
        logic [7:0] wr_list [$];
        int lat, ir_cnt;

        n_checks = 0; n_fail = 0; edge_n = 0; check_en = 0;
        ovf_m = 0; rd_busy = 0; in_prev = 0; rd_a = 0; rd_addr = 0;
        reset = 1; addr_bus = 0; c_ri = 0; c_ro = 0; mem_clk = 0; mem_io = 0;
        out_ready = 0; in_valid = 0; in_data = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
        tb_drv = 0; tb_data = 0;

        applyStimulus();
        check_en = 1;
        applyStimulus();
        reset = 0;
        checkBit("rst_out_valid", out_valid_seen, 1'b0);
        checkBit("rst_ovf", ovf_seen, 1'b0);
        checkBit("rst_in_ready", in_ready_seen, 1'b0);
        checkBit("rst_bus_hiz", bus_z_seen, 1'b1);

        // Program-loaded byte read back with the expected latency, then bus released.
        progWrite(8'h10, 8'h3C);
        cpuRead(8'h10, 1, d, lat);
        checkOutput("s1_data", d, 8'h3C);
        checkOutput("s1_latency", lat[7:0], 8'd2);
        applyStimulus();
        checkBit("s1_release", bus_z_seen, 1'b1);

        // Program write beats a CPU write to the same address on the same edge.
        c_ri = 1; mem_clk = 1; mem_io = 0; addr_bus = 8'h20; tb_drv = 1; tb_data = 8'hA5;
        prog_we = 1; prog_addr = 8'h20; prog_data = 8'h11;
        applyStimulus();
        c_ri = 0; mem_clk = 0; tb_drv = 0; prog_we = 0;
        cpuRead(8'h20, 0, d, lat);
        checkOutput("s2_prog_wins", d, 8'h11);

        // Overfill the output FIFO, then drain in order.
        out_ready = 0;
        for (int i = 1; i <= 5; i++) cpuWrite(1'b1, 8'h00, 8'(i), 1'b0);
        applyStimulus();
        checkBit("s3_ovf", ovf_seen, 1'b1);
        checkOutput("s3_head", out_data_seen, 8'h01);
        drain(8, got);
        checkOutput("s3_count", 8'(got.size()), 8'd4);
        for (int i = 0; i < got.size() && i < 4; i++) checkOutput("s3_order", got[i], 8'(i + 1));

        // Input port stalls with in_valid low, then delivers with a single in_ready pulse.
        c_ro = 1; mem_io = 1; in_valid = 0; in_data = 8'h7E;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkBit("s4_stall_hiz", bus_z_seen, 1'b1);
        end
        in_valid = 1;
        ir_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            if (in_ready_seen) ir_cnt++;
            checkOutput("s4_in_data", bus_seen, 8'h7E);
        end
        checkOutput("s4_ready_pulses", 8'(ir_cnt), 8'd1);
        c_ro = 0; mem_io = 0; in_valid = 0;
        applyStimulus();

        // Reset in the middle of a DRIVE: bus released immediately, FIFO and flag cleared.
        cpuWrite(1'b1, 8'h00, 8'h55, 1'b0);
        cpuWrite(1'b1, 8'h00, 8'h66, 1'b0);
        c_ro = 1; mem_clk = 1; mem_io = 0; addr_bus = 8'h10;
        applyStimulus();
        mem_clk = 0;
        applyStimulus();
        applyStimulus();
        checkOutput("s5_driving", bus_seen, 8'h3C);
        reset = 1; c_ro = 0;
        applyStimulus();
        checkBit("s5_reset_hiz", bus_z_seen, 1'b1);
        reset = 0;
        applyStimulus();
        checkBit("s5_after_hiz", bus_z_seen, 1'b1);
        checkBit("s5_fifo_empty", out_valid_seen, 1'b0);
        checkBit("s5_ovf_clear", ovf_seen, 1'b0);
        cpuRead(8'h10, 0, d, lat);
        checkOutput("s5_ram_kept", d, 8'h3C);

        // Full FIFO with a simultaneous pop and push: push lands, no overflow.
        for (int i = 0; i < 4; i++) cpuWrite(1'b1, 8'h00, 8'(8'h21 + i), 1'b0);
        out_ready = 1; c_ri = 1; mem_clk = 1; mem_io = 1; tb_drv = 1; tb_data = 8'h99;
        applyStimulus();
        c_ri = 0; mem_clk = 0; tb_drv = 0;
        got.delete();
        if (out_valid_seen) got.push_back(out_data_seen);
        begin
            logic [7:0] rest [$];
            drain(8, rest);
            foreach (rest[i]) got.push_back(rest[i]);
        end
        checkOutput("s6_count", 8'(got.size()), 8'd5);
        if (got.size() > 0) begin
            checkOutput("s6_first", got[0], 8'h21);
            checkOutput("s6_last", got[got.size() - 1], 8'h99);
        end
        checkBit("s6_no_ovf", ovf_seen, 1'b0);

        // Randomized mix of all transaction types; the compare process checks every cycle.
        wr_list.push_back(8'h10);
        wr_list.push_back(8'h20);
        for (int it = 0; it < 250; it++) begin
            int op;
            logic [7:0] a, v;
            op        = $urandom_range(0, 5);
            a         = 8'($urandom);
            v         = 8'($urandom_range(1, 255));
            out_ready = ($urandom_range(0, 2) != 0);
            case (op)
                0: begin
                    progWrite(a, v);
                    wr_list.push_back(a);
                end
                1: begin
                    if ($urandom_range(0, 3) == 0) begin
                        prog_we = 1; prog_addr = 8'($urandom); prog_data = 8'($urandom_range(1, 255));
                        wr_list.push_back(prog_addr);
                    end else begin
                        wr_list.push_back(a);
                    end
                    cpuWrite(1'b0, a, v, 1'($urandom_range(0, 1)));
                    prog_we = 0;
                end
                2: begin
                    cpuRead(wr_list[$urandom_range(0, wr_list.size() - 1)],
                            $urandom_range(0, 2), d, lat);
                end
                3: cpuWrite(1'b1, a, v, 1'($urandom_range(0, 1)));
                4: begin
                    c_ro = 1; mem_io = 1; in_data = v;
                    repeat ($urandom_range(1, 4)) begin
                        in_valid = 1'($urandom_range(0, 1));
                        mem_clk  = 1'($urandom_range(0, 1));
                        applyStimulus();
                    end
                    c_ro = 0; mem_io = 0; in_valid = 0; mem_clk = 0;
                end
                default: repeat ($urandom_range(1, 3)) applyStimulus();
            endcase
        end
        out_ready = 0;
        applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 SHALL expose parameter READ_LAT, default 1, clocks from read strobe accepted to bus driven (legal range 1..4).
REQ-002 SHALL expose parameter OUT_DEPTH, default 4, output-port FIFO entries (power of two, 2..16).
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on rising clk only.
REQ-005 addr_bus  input  8  CPU memory address.
REQ-006 c_ri  input  1  CPU write strobe: RAM write, or port write when mem_io=1.
REQ-007 c_ro  input  1  CPU read strobe: RAM read, or port read when mem_io=1.
REQ-008 mem_clk  input  1  CPU memory phase enable; strobes act only in cycles where mem_clk=1.
REQ-009 mem_io  input  1  1 selects I/O port, 0 selects RAM.
REQ-010 bus  inout  8  shared tri-state data bus; high-Z whenever not driving.
REQ-011 out_data / out_valid / out_ready  output 8 / output 1 / input 1  output-port stream, transfer when valid&&ready.
REQ-012 in_data / in_valid / in_ready  input 8 / input 1 / output 1  input-port stream, transfer when valid&&ready.
REQ-013 prog_we / prog_addr / prog_data  input 1 / 8 / 8  program-load write port.
REQ-014 out_ovf  output  1  sticky: an OUT write was dropped on a full FIFO.

Function
REQ-015 SHALL hold a 256x8 RAM; a strobe is "accepted" when its signal=1 and mem_clk=1 at a rising clk.
REQ-016 RAM write: accepted c_ri with mem_io=0 writes bus to RAM[addr_bus] at that edge.
REQ-017 prog_we=1 writes prog_data to RAM[prog_addr]; on the same edge as a CPU RAM write it wins and the CPU write is discarded.
REQ-018 Read FSM states IDLE, WAIT, DRIVE; IDLE->WAIT on accepted c_ro with mem_io=0, latching addr_bus.
REQ-019 WAIT SHALL count READ_LAT-1 further cycles, then enter DRIVE; with READ_LAT=1 it is one WAIT cycle.
REQ-020 DRIVE SHALL drive RAM[latched addr] on bus combinationally from state; DRIVE->IDLE on the first edge where c_ro=0.
REQ-021 c_ri and c_ro accepted together: the read is performed and the write is ignored.
REQ-022 OUT: accepted c_ri with mem_io=1 pushes bus into the FIFO; out_data/out_valid reflect the FIFO head.
REQ-023 Push on a full FIFO is accepted only if a pop occurs on the same edge; otherwise it is dropped and out_ovf is set.
REQ-024 Push and pop on the same edge on an empty FIFO: the entry is stored and out_valid rises the next cycle (no bypass).
REQ-025 Pointers SHALL wrap modulo OUT_DEPTH; count SHALL be log2(OUT_DEPTH)+1 bits wide.
REQ-026 IN: while c_ro=1, mem_io=1 and in_valid=1, the block SHALL drive in_data on bus.
REQ-027 in_ready SHALL pulse for exactly one cycle, on the first cycle of each such drive window.
REQ-028 IN with in_valid=0: bus stays high-Z, which stalls the CPU until in_valid rises.
REQ-029 bus SHALL never be driven by RAM-read and IN in the same cycle; the port path requires mem_io=1 and the FSM path requires mem_io=0 at acceptance.

Reset
REQ-030 On reset: FSM=IDLE, bus high-Z in the same cycle, FIFO empty, out_valid=0, out_ovf=0, in_ready=0.
REQ-031 RAM contents SHALL be retained across reset.
REQ-032 Reset during WAIT or DRIVE SHALL abort the read with no bus drive afterward.

Structure
REQ-033 Read FSM state enum and the RAM depth constant (256) SHALL live in shared package cpu_pkg.
REQ-034 The output FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH) with push/pop/full/empty/count ports.

Verification
REQ-035 Scenario: prog writes 0x3C to addr 0x10; CPU read of 0x10 -> bus=0x3C on cycle 2 after acceptance, high-Z once c_ro falls.
REQ-036 Scenario: CPU writes 0xA5 to 0x20 while prog_we writes 0x11 to 0x20 on the same edge -> a later read returns 0x11.
REQ-037 Scenario: OUT 0x01..0x05 with out_ready=0 and OUT_DEPTH=4 -> FIFO holds 0x01..0x04 and out_ovf=1; draining yields 0x01,0x02,0x03,0x04 in order.
REQ-038 Scenario: IN with in_valid=0 for 5 cycles, then in_data=0x7E with in_valid=1 -> bus stays Z, then shows 0x7E; in_ready is high for exactly one cycle.
REQ-039 Scenario: assert reset during DRIVE -> bus is Z in the reset cycle, FIFO empty, out_ovf=0, and RAM[0x10] still reads 0x3C.
REQ-040 Scenario: full FIFO with out_ready=1 and a simultaneous push of 0x99 -> push accepted, out_ovf stays 0, 0x99 emerges last.
